regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Arbitrates the single register-file write port between two writeback requesters: req0 is the ALU result path and req1 is the load/memory path. Each cycle it grants at most one requester using round-robin priority, and produces the 2:1 mux select that steers the 32-bit write data and 5-bit write address. The write port is driven from registered outputs. The block sits between the execute/memory stages and the register file.

Parameters:
DATA_W, 32, write-data width
ADDR_W, 5, register-address width
ZERO_DROP, 1, when 1, writes to register 0 are accepted but never issued to the port
CNT_W, 16, width of the saturating conflict counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  when 1, no grant is issued; all req_ready are 0
req0_valid  in  1  requester 0 has a write pending
req0_ready  out  1  requester 0 is granted this cycle
req0_addr  in  ADDR_W  requester 0 destination register
req0_data  in  DATA_W  requester 0 write data
req1_valid  in  1  requester 1 has a write pending
req1_ready  out  1  requester 1 is granted this cycle
req1_addr  in  ADDR_W  requester 1 destination register
req1_data  in  DATA_W  requester 1 write data
wr_sel  out  1  registered mux select (0 = req0, 1 = req1)
wr_en  out  1  register-file write enable, one-cycle pulse
wr_addr  out  ADDR_W  registered write address
wr_data  out  DATA_W  registered write data
conflict_cnt  out  CNT_W  number of cycles in which both requesters were valid and not stalled; saturates

Behaviour:
- Single clock domain.
- rst_n is asynchronous and active-low.
- Reset values:
  - wr_en = 0, wr_sel = 0, wr_addr = 0, wr_data = 0, conflict_cnt = 0.
  - Priority pointer prio = 0, meaning req0 is favoured.
- Grant logic (combinational, same cycle):
  - stall = 1: no grant.
  - Only one requester valid: that requester is granted.
  - Both valid: the requester equal to prio is granted.
  - reqN_ready = grant to N. Ready never depends on the other requester's ready.
- Transfer: a write transfers on a rising edge where reqN_valid and reqN_ready are both 1.
- Pointer update: on a transfer from requester N, prio <= not N. With no transfer, prio holds.
- Output stage (1-cycle latency), on the edge after a transfer:
  - wr_sel <= N.
  - wr_addr <= reqN_addr.
  - wr_data <= reqN_data.
  - wr_en <= 1, except wr_en <= 0 when ZERO_DROP = 1 and reqN_addr = 0.
  - A register-0 write is still a transfer: it consumes the grant and updates prio.
- No transfer: wr_en <= 0. wr_sel, wr_addr and wr_data hold their previous values.
- Back-to-back transfers: one transfer per cycle is allowed, so wr_en can stay high for consecutive cycles.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1... No requester waits more than one cycle while the other holds priority.
- conflict_cnt:
  - Increments by 1 on each edge where req0_valid = 1, req1_valid = 1 and stall = 0.
  - Holds at 2^CNT_W - 1.
  - Cleared only by reset.
- Stall:
  - Blocks new grants only.
  - An output already registered still presents its wr_en pulse for its one cycle.
  - prio holds during stall.
- Requester rules: a requester must hold valid, addr and data stable until ready. The arbiter does not check this.
- Reset mid-operation:
  - All outputs return to their reset values immediately, without waiting for a clock edge.
  - A pending request is lost.
  - prio = 0 after reset deasserts.
- Both outputs (wr_* and reqN_ready) must be free of X whenever rst_n = 0.

Test Plan:
- Reset then idle: hold rst_n = 0, then release with no valid -> wr_en = 0, conflict_cnt = 0, req0_ready = req1_ready = 0 for 10 cycles.
- Single requester:
  - Stimulus: req1_valid = 1, addr = 5'd7, data = 32'hDEADBEEF for 1 cycle.
  - Required: req1_ready = 1 in the same cycle.
  - Required next cycle: wr_en = 1, wr_sel = 1, wr_addr = 7, wr_data = 32'hDEADBEEF.
  - Required the cycle after: wr_en = 0.
- Contention round-robin:
  - Stimulus: both valid for 4 cycles.
  - Required grants: req0, req1, req0, req1.
  - Required: wr_sel sequence 0,1,0,1 delayed by 1 cycle; conflict_cnt = 4.
- Zero-register drop:
  - Stimulus: req0 writes addr 0, data 32'h12345678.
  - Required: req0_ready = 1, wr_en stays 0, prio moves to 1.
  - Required: a following contention cycle grants req1.
- Stall:
  - Stimulus: assert stall with both valid for 3 cycles, then deassert.
  - Required: no ready and no wr_en during stall; conflict_cnt unchanged; the first grant after stall goes to the prio holder.
- Async reset mid-transfer:
  - Stimulus: drop rst_n between edges while wr_en = 1.
  - Required: wr_en = 0 and wr_data = 0 immediately; after release, a contention cycle grants req0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the single register-file write port, shared by the
// ALU writeback path (req0) and the load path (req1). Write port is registered.
module regfile_wb_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter bit ZERO_DROP = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              wr_sel,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // prio names the requester that wins when both are valid.
  logic              prio;
  logic              grant0;
  logic              grant1;
  logic              xfer;
  logic              xfer_sel;
  logic [ADDR_W-1:0] xfer_addr;
  logic [DATA_W-1:0] xfer_data;
  logic              conflict;

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    grant0    = 1'b0;
    grant1    = 1'b0;
    xfer_sel  = 1'b0;
    xfer_addr = req0_addr;
    xfer_data = req0_data;
    if (!stall) begin
      if (req0_valid && req1_valid) begin
        grant0 = (prio == 1'b0);
        grant1 = (prio == 1'b1);
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
    if (grant1) begin
      xfer_sel  = 1'b1;
      xfer_addr = req1_addr;
      xfer_data = req1_data;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign xfer       = grant0 | grant1;
  assign conflict   = req0_valid & req1_valid & ~stall;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= 1'b0;
    end else if (xfer) begin
      prio <= ~xfer_sel;
    end
  end

  // Register-0 writes still move the datapath; only the enable is suppressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_sel  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= 1'b0;
      if (xfer) begin
        wr_sel  <= xfer_sel;
        wr_addr <= xfer_addr;
        wr_data <= xfer_data;
        wr_en   <= !(ZERO_DROP && (xfer_addr == '0));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (conflict && (conflict_cnt != CNT_MAX)) begin
      conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, single write, round-robin,
// register-0 drop, stall and asynchronous reset in the middle of a write.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        wr_sel, wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [15:0] conflict_cnt;

  int total = 0;
  int bad   = 0;

  regfile_wb_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_addr    (req0_addr),
    .req0_data    (req0_data),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_addr    (req1_addr),
    .req1_data    (req1_data),
    .wr_sel       (wr_sel),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;

    // Reset then idle
    step(); step();
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_ready0", 32'(req0_ready), 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_wr_en", 32'(wr_en), 32'd0);
      check("idle_cnt", 32'(conflict_cnt), 32'd0);
      check("idle_ready0", 32'(req0_ready), 32'd0);
      check("idle_ready1", 32'(req1_ready), 32'd0);
    end

    // Single requester: req1 writes r7
    req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'hDEADBEEF;
    #1;
    check("single_ready1", 32'(req1_ready), 32'd1);
    check("single_ready0", 32'(req0_ready), 32'd0);
    step();
    req1_valid = 1'b0;
    check("single_wr_en", 32'(wr_en), 32'd1);
    check("single_wr_sel", 32'(wr_sel), 32'd1);
    check("single_wr_addr", 32'(wr_addr), 32'd7);
    check("single_wr_data", wr_data, 32'hDEADBEEF);
    step();
    check("single_wr_en_off", 32'(wr_en), 32'd0);
    check("single_data_hold", wr_data, 32'hDEADBEEF);

    // Contention: 4 cycles, grants alternate starting with req0
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'hA0A0A0A0;
    req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'hB1B1B1B1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_ready0", 32'(req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_ready1", 32'(req1_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
      step();
      check("rr_wr_en", 32'(wr_en), 32'd1);
      check("rr_wr_sel", 32'(wr_sel), 32'(i % 2));
      check("rr_wr_addr", 32'(wr_addr), (i % 2 == 0) ? 32'd1 : 32'd2);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("rr_cnt", 32'(conflict_cnt), 32'd4);

    // Zero-register drop: consumes grant, no write, prio moves to req1
    req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'h12345678;
    #1;
    check("zero_ready0", 32'(req0_ready), 32'd1);
    step();
    req0_valid = 1'b0;
    check("zero_wr_en", 32'(wr_en), 32'd0);
    check("zero_wr_data", wr_data, 32'h12345678);
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h33333333;
    req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h44444444;
    #1;
    check("zero_next_ready1", 32'(req1_ready), 32'd1);
    check("zero_next_ready0", 32'(req0_ready), 32'd0);
    step();
    check("zero_next_sel", 32'(wr_sel), 32'd1);
    check("zero_next_en", 32'(wr_en), 32'd1);
    // One more contention cycle: req0 wins, prio goes to req1
    #1;
    check("pre_stall_ready0", 32'(req0_ready), 32'd1);
    step();
    check("pre_stall_cnt", 32'(conflict_cnt), 32'd6);

    // Stall: no grants, pending pulse still visible, counter frozen
    stall = 1'b1;
    check("stall_pending_en", 32'(wr_en), 32'd1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_ready0", 32'(req0_ready), 32'd0);
      check("stall_ready1", 32'(req1_ready), 32'd0);
      step();
      check("stall_wr_en", 32'(wr_en), 32'd0);
      check("stall_cnt", 32'(conflict_cnt), 32'd6);
    end
    stall = 1'b0;
    #1;
    check("post_stall_ready1", 32'(req1_ready), 32'd1);
    check("post_stall_ready0", 32'(req0_ready), 32'd0);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("post_stall_sel", 32'(wr_sel), 32'd1);
    check("post_stall_data", wr_data, 32'h44444444);
    check("post_stall_cnt", 32'(conflict_cnt), 32'd7);

    // Async reset while wr_en is high; req0 transfer leaves prio on req1
    req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'hCAFEF00D;
    step();
    req0_valid = 1'b0;
    check("arst_pre_en", 32'(wr_en), 32'd1);
    check("arst_pre_data", wr_data, 32'hCAFEF00D);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_wr_en", 32'(wr_en), 32'd0);
    check("arst_wr_data", wr_data, 32'd0);
    check("arst_wr_addr", 32'(wr_addr), 32'd0);
    check("arst_cnt", 32'(conflict_cnt), 32'd0);
    step();
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'h55555555;
    req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'h66666666;
    #1;
    check("arst_after_ready0", 32'(req0_ready), 32'd1);
    check("arst_after_ready1", 32'(req1_ready), 32'd0);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("arst_after_sel", 32'(wr_sel), 32'd0);
    check("arst_after_data", wr_data, 32'h55555555);
    check("arst_after_cnt", 32'(conflict_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
